// File: rtl/tdl_tdc_channel.sv
`timescale 1ps/1ps
// Tapped-delay-line fine-time stage: delay chain, two-flop tap capture,
// a snapshot frozen by sample, and a pipelined popcount/bubble encoder.
module tdl_tdc_channel #(
    parameter int N_TAPS           = 64,
    parameter int ENC_STAGES       = 2,
    parameter int SIM_TAP_DELAY_PS = 500,
    localparam int CW              = $clog2(N_TAPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          signal_in,
    input  logic          sample,
    input  logic          edge_sel,
    output logic [CW-1:0] fine_count,
    output logic          fine_valid,
    output logic          overflow,
    output logic          empty,
    output logic          bubble
);

    // The snapshot is split into LEAVES chunks; each encoder stage halves the partial sums.
    localparam int LEAVES = 1 << (ENC_STAGES - 1);
    localparam int CHUNK  = (N_TAPS + LEAVES - 1) / LEAVES;
    localparam int PAD_W  = LEAVES * CHUNK;
    localparam logic [CW-1:0] FULL = CW'(N_TAPS);

    logic [N_TAPS:0]       chain;
    logic [N_TAPS-1:0]     cap1;
    logic [N_TAPS-1:0]     cap2;
    logic [N_TAPS-1:0]     snap;
    logic                  snap_v;
    logic [PAD_W-1:0]      snap_pad;
    logic                  snap_bubble;
    logic [CW-1:0]         node [1:2*LEAVES-1];
    logic [ENC_STAGES-1:0] v_pipe;
    logic [ENC_STAGES-1:0] b_pipe;

    assign chain[0] = signal_in;

    for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
`ifdef SYNTHESIS
        (* keep *) SB_LUT4 #(
            .LUT_INIT(16'haaaa)
        ) u_lut (
            .O (chain[i+1]),
            .I0(chain[i]),
            .I1(1'b0),
            .I2(1'b0),
            .I3(1'b0)
        );
`else
        assign #(SIM_TAP_DELAY_PS) chain[i+1] = chain[i];
`endif
    end

    always_comb begin
        snap_pad = '0;
        snap_pad[N_TAPS-1:0] = snap;
    end

    // A clean code has ones only at the low end, so any 0 directly below a 1 is a bubble.
    assign snap_bubble = |(~snap[N_TAPS-2:0] & snap[N_TAPS-1:1]);

    function automatic logic [CW-1:0] count_ones(input logic [CHUNK-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap1       <= '0;
            cap2       <= '0;
            snap       <= '0;
            snap_v     <= 1'b0;
            v_pipe     <= '0;
            b_pipe     <= '0;
            for (int n = 1; n < 2 * LEAVES; n++) node[n] <= '0;
            fine_count <= '0;
            fine_valid <= 1'b0;
            overflow   <= 1'b0;
            empty      <= 1'b0;
            bubble     <= 1'b0;
        end else begin
            cap1   <= chain[N_TAPS:1];
            cap2   <= cap1;
            snap_v <= sample;
            if (sample) snap <= edge_sel ? ~cap2 : cap2;

            // Free-running adder tree: leaves are stage 1, node[1] is the final stage.
            for (int k = 0; k < LEAVES; k++)
                node[LEAVES+k] <= count_ones(snap_pad[k*CHUNK +: CHUNK]);
            for (int n = 1; n < LEAVES; n++)
                node[n] <= node[2*n] + node[2*n+1];

            v_pipe[0] <= snap_v;
            b_pipe[0] <= snap_bubble;
            for (int s = 1; s < ENC_STAGES; s++) begin
                v_pipe[s] <= v_pipe[s-1];
                b_pipe[s] <= b_pipe[s-1];
            end

            fine_valid <= v_pipe[ENC_STAGES-1];
            if (v_pipe[ENC_STAGES-1]) begin
                fine_count <= node[1];
                overflow   <= (node[1] == FULL);
                empty      <= (node[1] == '0);
                bubble     <= b_pipe[ENC_STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_tdl_tdc_channel.sv
`timescale 1ps/1ps
// Bench for tdl_tdc_channel: directed signal_in waveforms, a model that derives
// each snapshot from the recorded waveform history, and a per-cycle output checker.
module tb_tdl_tdc_channel;

    localparam int N_TAPS     = 16;
    localparam int ENC_STAGES = 2;
    localparam int TAP_PS     = 500;
    localparam int CW         = 5;
    localparam int PERIOD     = 10000;
    localparam int LAT        = ENC_STAGES + 1;
    localparam int EW         = 32 + CW + 3;

    logic          clk;
    logic          rst_n;
    logic          signal_in;
    logic          sample;
    logic          edge_sel;
    logic [CW-1:0] fine_count;
    logic          fine_valid;
    logic          overflow;
    logic          empty;
    logic          bubble;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    longint          ev_t[$];
    logic            ev_v[$];
    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   held = '0;

    tdl_tdc_channel #(
        .N_TAPS          (N_TAPS),
        .ENC_STAGES      (ENC_STAGES),
        .SIM_TAP_DELAY_PS(TAP_PS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .sample    (sample),
        .edge_sel  (edge_sel),
        .fine_count(fine_count),
        .fine_valid(fine_valid),
        .overflow  (overflow),
        .empty     (empty),
        .bubble    (bubble)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waveform history of signal_in; a tap i at time t shows signal_in at t-(i+1)*TAP_PS.
    always @(signal_in) begin
        ev_t.push_back(longint'($time));
        ev_v.push_back(signal_in);
    end

    function automatic logic sig_at(input longint t);
        logic v;
        v = 1'b0;
        for (int k = 0; k < ev_t.size(); k++)
            if (ev_t[k] <= t) v = ev_v[k];
        return v;
    endfunction

    function automatic logic [EW-1:0] model_entry(input longint t_snap, input logic sel, input int due);
        int   ones;
        logic seen_zero;
        logic bub;
        logic v;
        ones      = 0;
        seen_zero = 1'b0;
        bub       = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            v = sig_at(t_snap - longint'((i + 1) * TAP_PS)) ^ sel;
            if (v) begin
                ones++;
                if (seen_zero) bub = 1'b1;
            end else begin
                seen_zero = 1'b1;
            end
        end
        return {due, CW'(ones), (ones == N_TAPS), (ones == 0), bub};
    endfunction

    // Model: a sample seen at a posedge freezes the taps as they were two clocks earlier.
    always @(posedge clk) begin
        cycle = cycle + 1;
        if (rst_n && sample)
            exp_q.push_back(model_entry(longint'($time) - 2 * PERIOD, edge_sel, cycle + LAT));
    end

    always @(negedge rst_n) exp_q.delete();

    // scoreboard / compare
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", int'(fine_valid), 0);
            chk("rst_count", int'(fine_count), 0);
            chk("rst_flags", int'({overflow, empty, bubble}), 0);
            held = '0;
        end else begin
            logic due_now;
            due_now = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) == cycle);
            chk("fine_valid", int'(fine_valid), int'(due_now));
            if (due_now) held = exp_q.pop_front();
            chk("fine_count", int'(fine_count), int'(held[CW+2:3]));
            chk("flags", int'({overflow, empty, bubble}), int'(held[2:0]));
        end
    end

    // driver tasks
    task automatic sample_now(input logic sel);
        @(negedge clk);
        sample   = 1'b1;
        edge_sel = sel;
        @(posedge clk);
        @(negedge clk);
        sample   = 1'b0;
        edge_sel = 1'b0;
    endtask

    // Puts a transition lead_ps before capture edge P (optionally a pulse of width_ps),
    // then samples at P+2 so the snapshot holds the taps seen at P.
    task automatic measure(input int lead_ps, input logic lvl, input int width_ps, input logic sel);
        @(posedge clk);
        #(PERIOD - lead_ps) signal_in = lvl;
        if (width_ps > 0) #(width_ps) signal_in = ~lvl;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sample   = 1'b1;
        edge_sel = sel;
        @(posedge clk);
        @(negedge clk);
        sample   = 1'b0;
        edge_sel = 1'b0;
    endtask

    // Hand-computed expectations; flags packed as {overflow, empty, bubble}.
    task automatic expect_lit(input string name, input int cnt, input int flags);
        int n;
        n = 0;
        @(negedge clk);
        while (!fine_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_seen"}, int'(fine_valid), 1);
        chk({name, "_count"}, int'(fine_count), cnt);
        chk({name, "_flags"}, int'({overflow, empty, bubble}), flags);
    endtask

    initial begin
        #(5_000_000);
        errors++;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        signal_in = 1'b0;
        sample    = 1'b0;
        edge_sel  = 1'b0;
        repeat (3) @(posedge clk);
        #2000 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", int'(fine_valid), 0);
        chk("reset_count", int'(fine_count), 0);
        chk("reset_flags", int'({overflow, empty, bubble}), 0);
        repeat (3) @(posedge clk);

        measure(3200, 1'b1, 0, 1'b0);
        expect_lit("rise", 6, 0);

        repeat (2) @(posedge clk);
        sample_now(1'b0);
        expect_lit("overflow", 16, 4);

        signal_in = 1'b0;
        repeat (3) @(posedge clk);
        sample_now(1'b0);
        expect_lit("empty", 0, 2);

        signal_in = 1'b1;
        repeat (3) @(posedge clk);
        measure(2100, 1'b0, 0, 1'b1);
        expect_lit("fall", 4, 0);

        repeat (3) @(posedge clk);
        measure(3200, 1'b1, 1000, 1'b0);
        expect_lit("bubble", 2, 1);

        // Waveform giving 2, 9 and 16 taps at three consecutive capture edges.
        repeat (3) @(posedge clk);
        #8800 signal_in = 1'b1;
        @(posedge clk);
        #1000 signal_in = 1'b0;
        #4300 signal_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample = 1'b0;
        expect_lit("b2b_0", 2, 0);
        expect_lit("b2b_1", 9, 0);
        expect_lit("b2b_2", 16, 4);

        // Two samples in flight when reset hits.
        @(negedge clk);
        sample = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample = 1'b0;
        #1000 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(fine_valid), 0);
        chk("async_rst_count", int'(fine_count), 0);
        chk("async_rst_flags", int'({overflow, empty, bubble}), 0);
        repeat (2) @(posedge clk);
        #2000 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (fine_valid) seen++;
        end
        chk("no_stale_valid", seen, 0);

        signal_in = 1'b0;
        repeat (3) @(posedge clk);
        measure(3200, 1'b1, 0, 1'b0);
        expect_lit("recover", 6, 0);

        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
